// File: rtl/dz_modem_scan_if.sv
// Event stream between the modem-status scanner and the DZ11 CSR logic.
//   evtVALID : an event is presented
//   evtLINE  : line number of the presented event
//   evtCO    : debounced carrier detect of evtLINE, captured at grant
//   evtRI    : debounced ring indicator of evtLINE, captured at grant
//   evtACK   : consumer accepts the presented event
// The scanner is the master; the CSR/interrupt logic is the slave.
interface dz_modem_scan_if;
  logic       evtVALID;
  logic [2:0] evtLINE;
  logic       evtCO;
  logic       evtRI;
  logic       evtACK;

  modport master (output evtVALID, output evtLINE, output evtCO, output evtRI, input evtACK);
  modport slave  (input evtVALID, input evtLINE, input evtCO, input evtRI, output evtACK);
endinterface

// File: rtl/dz_modem_scan.sv
// DZ11 modem-status scanner and event scheduler.
// Synchronizes and debounces per-line Carrier Detect / Ring Indicator,
// publishes the debounced status word, and turns per-line status changes
// into a round-robin arbitrated valid/ack event stream.
// Ports:
//   clk      : clock
//   rst      : asynchronous reset, active low
//   msrEN    : scan enable; low flushes pending events
//   dzCO     : raw carrier detect, bit n = line n
//   dzRI     : raw ring indicator, bit n = line n
//   regMSR   : debounced status {CO[7:0], RI[7:0]}
//   evt      : event stream (master side), see dz_modem_scan_if
//   pendMASK : lines with a pending, unserviced change
//   ovfl     : sticky, a change was lost because its line was already pending
//   ovflCLR  : clears ovfl (a simultaneous new overflow wins)
module dz_modem_scan #(
  parameter int DB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   msrEN,
  input  logic [7:0]             dzCO,
  input  logic [7:0]             dzRI,
  output logic [15:0]            regMSR,
  dz_modem_scan_if.master        evt,
  output logic [7:0]             pendMASK,
  output logic                   ovfl,
  input  logic                   ovflCLR
);

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [7:0] co_meta_r, ri_meta_r;
  logic [7:0] co_sync_r, ri_sync_r;
  logic [7:0] co_db_s, ri_db_s;
  logic [7:0] upd_s;

  logic [7:0] pend_r, pend_nxt_s, clr_s;
  logic       ovfl_r, ovfl_set_s;

  state_t     state_r, state_nxt_s;
  logic [2:0] ptr_r, ptr_nxt_s;
  logic [2:0] line_r, line_nxt_s;
  logic       co_evt_r, co_evt_nxt_s;
  logic       ri_evt_r, ri_evt_nxt_s;
  logic       valid_r, valid_nxt_s;

  logic       grant_found_s;
  logic [2:0] grant_line_s;
  logic [2:0] cand_s;

  // Two-flop synchronizer on all raw modem inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      co_meta_r <= 8'h00;
      ri_meta_r <= 8'h00;
      co_sync_r <= 8'h00;
      ri_sync_r <= 8'h00;
    end else begin
      co_meta_r <= dzCO;
      ri_meta_r <= dzRI;
      co_sync_r <= co_meta_r;
      ri_sync_r <= ri_meta_r;
    end
  end

  // Per-line debounce: the {CO,RI} pair must differ from the stable value
  // for DB_CYCLES consecutive cycles before the stable value follows it.
  // Any change of the pair within the run keeps counting; only a match resets.
  for (genvar n = 0; n < 8; n++) begin : g_line
    logic [1:0] pair_s;
    logic [1:0] db_r;
    logic [3:0] cnt_r;
    logic       differ_s;
    logic       load_s;

    assign pair_s   = {co_sync_r[n], ri_sync_r[n]};
    assign differ_s = (pair_s != db_r);
    assign load_s   = differ_s && (cnt_r == DB_LAST);

    // Debounce counter and stable status of this line
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r <= 4'd0;
        db_r  <= 2'b00;
      end else if (load_s) begin
        cnt_r <= 4'd0;
        db_r  <= pair_s;
      end else if (differ_s) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
    end

    assign co_db_s[n] = db_r[1];
    assign ri_db_s[n] = db_r[0];
    assign upd_s[n]   = load_s;
  end

  assign regMSR = {co_db_s, ri_db_s};

  // Pending-mask next state. A change on the line being acked on the same
  // edge simply re-pends it (set beats clear) and is not an overflow.
  always_comb begin
    clr_s      = (state_r == PRESENT && evt.evtACK) ? (8'h01 << line_r) : 8'h00;
    ovfl_set_s = msrEN & (|(upd_s & pend_r & ~clr_s));
    pend_nxt_s = msrEN ? ((pend_r & ~clr_s) | upd_s) : 8'h00;
  end

  // Pending mask and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 8'h00;
      ovfl_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      if (ovfl_set_s) begin
        ovfl_r <= 1'b1;
      end else if (ovflCLR) begin
        ovfl_r <= 1'b0;
      end else begin
        ovfl_r <= ovfl_r;
      end
    end
  end

  // Round-robin search: first pending line after ptr_r, wrapping mod 8.
  // Walking downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    grant_found_s = |pend_r;
    grant_line_s  = 3'd0;
    cand_s        = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      cand_s = ptr_r + 3'(i);
      if (pend_r[cand_s]) begin
        grant_line_s = cand_s;
      end else begin
        grant_line_s = grant_line_s;
      end
    end
  end

  // Event FSM next-state and registered event fields
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    line_nxt_s   = line_r;
    co_evt_nxt_s = co_evt_r;
    ri_evt_nxt_s = ri_evt_r;
    valid_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (msrEN && grant_found_s) begin
          state_nxt_s  = PRESENT;
          line_nxt_s   = grant_line_s;
          co_evt_nxt_s = co_db_s[grant_line_s];
          ri_evt_nxt_s = ri_db_s[grant_line_s];
          valid_nxt_s  = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
          valid_nxt_s  = 1'b0;
        end
      end
      PRESENT: begin
        if (!msrEN) begin
          state_nxt_s = IDLE;
          valid_nxt_s = 1'b0;
        end else if (evt.evtACK) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = line_r;
          valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = PRESENT;
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Event FSM state, round-robin pointer and presented event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= 3'd7;
      line_r   <= 3'd0;
      co_evt_r <= 1'b0;
      ri_evt_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      line_r   <= line_nxt_s;
      co_evt_r <= co_evt_nxt_s;
      ri_evt_r <= ri_evt_nxt_s;
      valid_r  <= valid_nxt_s;
    end
  end

  assign evt.evtVALID = valid_r;
  assign evt.evtLINE  = line_r;
  assign evt.evtCO    = co_evt_r;
  assign evt.evtRI    = ri_evt_r;
  assign pendMASK     = pend_r;
  assign ovfl         = ovfl_r;

endmodule
